// File: rtl/rx_lbuf_fill_if.sv
// Handshake bundle of rx_lbuf_fill: lbuf grant/return, chunk request/grant, write-done, header write.
// The slave modport is the buffer filler; master is the provider / write engine side.
interface rx_lbuf_fill_if;
  logic [63:0] lbuf_addr;
  logic        lbuf_en;
  logic        lbuf64b;
  logic        lbuf_dn;
  logic        chnk_req;
  logic [12:0] chnk_len;
  logic        chnk_gnt;
  logic [63:0] chnk_addr;
  logic        chnk_64b;
  logic        wr_done;
  logic        hdr_req;
  logic [63:0] hdr_addr;
  logic [31:0] hdr_used;
  logic        hdr_ack;

  modport slave (
    input  lbuf_addr, lbuf_en, lbuf64b, chnk_req, chnk_len, wr_done, hdr_ack,
    output lbuf_dn, chnk_gnt, chnk_addr, chnk_64b, hdr_req, hdr_addr, hdr_used
  );

  modport master (
    output lbuf_addr, lbuf_en, lbuf64b, chnk_req, chnk_len, wr_done, hdr_ack,
    input  lbuf_dn, chnk_gnt, chnk_addr, chnk_64b, hdr_req, hdr_addr, hdr_used
  );
endinterface

// File: rtl/rx_lbuf_fill.sv
// rx_lbuf_fill: carves a granted lbuf into chunk write addresses, tracks writes in flight and
// returns the lbuf on full or idle timeout. Define RX_LBUF_HDR_EN for the leading header write.
module rx_lbuf_fill #(
  parameter int unsigned LBUF_SIZE_LOG2 = 21,
  parameter int unsigned TIMEOUT_CYC    = 1000,
  parameter int unsigned MAX_OUTST      = 16,
  parameter int unsigned HDR_BYTES      = 64
) (
  input logic           clk,
  input logic           rst,
  rx_lbuf_fill_if.slave bus
);

`ifdef RX_LBUF_HDR_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  localparam int unsigned OffW = LBUF_SIZE_LOG2 + 1;
  // Room for offset + chunk length without overflow, whatever the lbuf size.
  localparam int unsigned SumW = ((OffW > 13) ? OffW : 13) + 1;
  localparam int unsigned OutW = $clog2(MAX_OUTST + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [OffW-1:0] LbufFull = OffW'(1) << LBUF_SIZE_LOG2;
  localparam logic [OffW-1:0] Start    = HdrEn ? OffW'(HDR_BYTES) : '0;
  localparam logic [OutW-1:0] OutMax   = OutW'(MAX_OUTST);
  localparam logic [TmrW-1:0] TmrMax   = TmrW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StFlush,
    StHdr,
    StDone,
    StGap
  } state_e;

  state_e          state_q;
  logic [63:0]     base_q;
  logic [OffW-1:0] offset_q;
  logic [OutW-1:0] outst_q;
  logic [TmrW-1:0] timer_q;
  logic            lbuf_dn_q;
  logic            chnk_gnt_q;
  logic [63:0]     chnk_addr_q;
  logic            chnk_64b_q;
`ifdef RX_LBUF_HDR_EN
  logic            hdr_req_q;
  logic [31:0]     hdr_used_q;
`endif

  logic            req_live;
  logic            fits;
  logic            room;
  logic            grant;
  logic            done_dec;
  logic            has_data;
  logic            timed_out;
  logic [SumW-1:0] end_off;
  logic [63:0]     addr_sum;
  logic [OutW-1:0] outst_d;

  always_comb begin
    // The request is still high in the grant cycle; it belongs to the chunk just granted.
    req_live  = bus.chnk_req & ~chnk_gnt_q;
    end_off   = SumW'(offset_q) + SumW'(bus.chnk_len);
    fits      = end_off <= SumW'(LbufFull);
    room      = outst_q < OutMax;
    grant     = (state_q == StArmed) & req_live & fits & room;
    done_dec  = bus.wr_done & (outst_q != '0);
    has_data  = offset_q > Start;
    timed_out = has_data & (timer_q == TmrMax);
    addr_sum  = base_q + 64'(offset_q);

    unique case ({grant, done_dec})
      2'b10:   outst_d = outst_q + OutW'(1);
      2'b01:   outst_d = outst_q - OutW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      offset_q    <= '0;
      outst_q     <= '0;
      timer_q     <= '0;
      lbuf_dn_q   <= 1'b0;
      chnk_gnt_q  <= 1'b0;
      chnk_addr_q <= '0;
      chnk_64b_q  <= 1'b0;
`ifdef RX_LBUF_HDR_EN
      hdr_req_q   <= 1'b0;
      hdr_used_q  <= '0;
`endif
    end else begin
      outst_q    <= outst_d;
      chnk_gnt_q <= grant;
      lbuf_dn_q  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.lbuf_en) begin
            base_q     <= bus.lbuf_addr;
            chnk_64b_q <= bus.lbuf64b;
            offset_q   <= Start;
            timer_q    <= '0;
            state_q    <= StArmed;
          end
        end

        StArmed: begin
          if (grant) begin
            chnk_addr_q <= chnk_64b_q ? addr_sum : {32'h0, addr_sum[31:0]};
            offset_q    <= end_off[OffW-1:0];
            timer_q     <= '0;
          end else if (req_live) begin
            // A chunk that cannot fit stays pending for the next lbuf.
            if (!fits) begin
              state_q <= StFlush;
            end
          end else if ((offset_q == LbufFull) || timed_out) begin
            state_q <= StFlush;
          end else if (!bus.chnk_req && has_data && (timer_q != TmrMax)) begin
            timer_q <= timer_q + TmrW'(1);
          end
        end

        StFlush: begin
          if (outst_q == '0) begin
`ifdef RX_LBUF_HDR_EN
            hdr_req_q  <= 1'b1;
            hdr_used_q <= 32'(offset_q);
            state_q    <= StHdr;
`else
            lbuf_dn_q  <= 1'b1;
            state_q    <= StDone;
`endif
          end
        end

        StHdr: begin
`ifdef RX_LBUF_HDR_EN
          if (bus.hdr_ack) begin
            hdr_req_q <= 1'b0;
            lbuf_dn_q <= 1'b1;
            state_q   <= StDone;
          end
`else
          lbuf_dn_q <= 1'b1;
          state_q   <= StDone;
`endif
        end

        StDone: state_q <= StGap;

        // Provider still holds lbuf_en for one cycle after lbuf_dn.
        StGap: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.lbuf_dn   = lbuf_dn_q;
  assign bus.chnk_gnt  = chnk_gnt_q;
  assign bus.chnk_addr = chnk_addr_q;
  assign bus.chnk_64b  = chnk_64b_q;

`ifdef RX_LBUF_HDR_EN
  assign bus.hdr_req  = hdr_req_q;
  assign bus.hdr_addr = base_q;
  assign bus.hdr_used = hdr_used_q;
`else
  logic unused_hdr_ack;
  assign unused_hdr_ack = bus.hdr_ack;
  assign bus.hdr_req    = 1'b0;
  assign bus.hdr_addr   = '0;
  assign bus.hdr_used   = '0;
`endif

endmodule

// File: tb/tb_rx_lbuf_fill.sv
// Directed self-checking bench for rx_lbuf_fill: chunk addresses via a scoreboard queue,
// full/timeout closes, outstanding limit, header write (when built with RX_LBUF_HDR_EN) and reset.
module tb_rx_lbuf_fill;
  localparam int unsigned LOG2  = 12;
  localparam int unsigned TMO   = 40;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned HDRB  = 64;
  localparam int unsigned LSIZE = 1 << LOG2;
`ifdef RX_LBUF_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif
  localparam int unsigned START = HDR_ON ? HDRB : 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_lbuf_fill_if bus ();

  rx_lbuf_fill #(
    .LBUF_SIZE_LOG2(LOG2),
    .TIMEOUT_CYC   (TMO),
    .MAX_OUTST     (MAXO),
    .HDR_BYTES     (HDRB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [64:0] exp_q[$];
  logic [63:0] m_base;
  bit          m_64;
  int unsigned m_off;
  int unsigned m_len;
  int          cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":lbuf_dn"},   64'(bus.lbuf_dn),  64'(0));
    check({tag, ":chnk_gnt"},  64'(bus.chnk_gnt), 64'(0));
    check({tag, ":chnk_addr"}, bus.chnk_addr,     64'(0));
    check({tag, ":chnk_64b"},  64'(bus.chnk_64b), 64'(0));
    check({tag, ":hdr_req"},   64'(bus.hdr_req),  64'(0));
    check({tag, ":hdr_addr"},  bus.hdr_addr,      64'(0));
    check({tag, ":hdr_used"},  64'(bus.hdr_used), 64'(0));
  endtask

  task automatic arm(input logic [63:0] base, input bit is64);
    @(negedge clk);
    bus.lbuf_addr = base;
    bus.lbuf64b   = is64;
    bus.lbuf_en   = 1'b1;
    m_base = base;
    m_64   = is64;
    m_off  = START;
  endtask

  task automatic push_req(input int unsigned len);
    logic [63:0] sum;
    sum = m_base + 64'(m_off);
    if (!m_64) sum[63:32] = '0;
    exp_q.push_back({m_64, sum});
    m_len         = len;
    bus.chnk_len  = 13'(len);
    bus.chnk_req  = 1'b1;
  endtask

  task automatic wait_gnt(input string tag, input int budget, input bit expect_gnt);
    logic [64:0] exp;
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      bus.wr_done = 1'b0;
      got = bus.chnk_gnt;
    end
    check({tag, ":gnt"}, 64'(got), 64'(expect_gnt));
    if (got) begin
      exp = exp_q.pop_front();
      check({tag, ":addr"}, bus.chnk_addr, exp[63:0]);
      check({tag, ":64b"}, 64'(bus.chnk_64b), 64'(exp[64]));
      m_off += m_len;
      bus.chnk_req = 1'b0;
    end else if (expect_gnt) begin
      void'(exp_q.pop_front());
      bus.chnk_req = 1'b0;
    end
  endtask

  task automatic req_chunk(input string tag, input int unsigned len);
    push_req(len);
    wait_gnt(tag, 20, 1'b1);
  endtask

  task automatic pulse_done(input int n);
    bus.wr_done = 1'b1;
    repeat (n) @(negedge clk);
    bus.wr_done = 1'b0;
  endtask

  task automatic watch_idle(input string tag, input int n);
    int dn  = 0;
    int gnt = 0;
    int hq  = 0;
    repeat (n) begin
      @(negedge clk);
      dn  += int'(bus.lbuf_dn);
      gnt += int'(bus.chnk_gnt);
      hq  += int'(bus.hdr_req);
    end
    check({tag, ":no_dn"},  64'(dn),  64'(0));
    check({tag, ":no_gnt"}, 64'(gnt), 64'(0));
    check({tag, ":no_hdr"}, 64'(hq),  64'(0));
  endtask

  task automatic close_lbuf(input string tag, input int unsigned used, input int budget,
                            output int cyc_o);
    bit seen_hdr = 1'b0;
    bit seen_dn  = 1'b0;
    int gnts     = 0;
    cyc_o = budget;
    for (int i = 0; i < budget && !seen_dn; i++) begin
      @(negedge clk);
      bus.hdr_ack = 1'b0;
      gnts += int'(bus.chnk_gnt);
      if (bus.hdr_req && !seen_hdr) begin
        seen_hdr = 1'b1;
        check({tag, ":hdr_used"}, 64'(bus.hdr_used), 64'(used));
        check({tag, ":hdr_addr"}, bus.hdr_addr, m_base);
        bus.hdr_ack = 1'b1;
      end
      if (bus.lbuf_dn) begin
        seen_dn = 1'b1;
        cyc_o   = i;
      end
    end
    bus.hdr_ack = 1'b0;
    check({tag, ":hdr_seen"}, 64'(seen_hdr), 64'(HDR_ON));
    check({tag, ":lbuf_dn"},  64'(seen_dn),  64'(1));
    check({tag, ":no_gnt"},   64'(gnts),     64'(0));
    @(negedge clk);
    check({tag, ":dn_1cyc"}, 64'(bus.lbuf_dn), 64'(0));
    bus.lbuf_en = 1'b0;
  endtask

  initial begin
    bus.lbuf_addr = '0;
    bus.lbuf_en   = 1'b0;
    bus.lbuf64b   = 1'b0;
    bus.chnk_req  = 1'b0;
    bus.chnk_len  = '0;
    bus.wr_done   = 1'b0;
    bus.hdr_ack   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    // 64-bit lbuf, three 1 KB chunks; close waits for all writes even after timeout.
    arm(64'h1_0000_0000, 1'b1);
    repeat (3) req_chunk("A", 1024);
    watch_idle("A:drain", TMO + 10);
    pulse_done(3);
    close_lbuf("A", START + 3072, 20, cyc);

    // 32-bit lbuf whose addresses cross 4 GB; oversize chunk closes and carries to next lbuf.
    arm(64'hFFFF_FC00, 1'b0);
    repeat (2) req_chunk("B", 1024);
    bus.chnk_len = 13'd3072;
    bus.chnk_req = 1'b1;
    pulse_done(2);
    close_lbuf("B", START + 2048, 20, cyc);
    arm(64'h2000_0000_0000, 1'b1);
    push_req(3072);
    wait_gnt("B:pend", 10, 1'b1);
    pulse_done(1);
    close_lbuf("B2", START + 3072, TMO + 20, cyc);

    // Exactly full lbuf: lbuf_dn only after the last write completes.
    arm(64'h5_0000_0000, 1'b1);
    repeat (4) req_chunk("C", (LSIZE - START) / 4);
    pulse_done(3);
    watch_idle("C:hold", 6);
    pulse_done(1);
    close_lbuf("C", LSIZE, 20, cyc);

    // Single 512-byte chunk then idle: timeout close.
    arm(64'h1234_0000, 1'b0);
    req_chunk("D", 512);
    pulse_done(1);
    close_lbuf("D", START + 512, TMO + 20, cyc);
    check("D:tmo_lo", 64'(cyc + 1 >= TMO), 64'(1));
    check("D:tmo_hi", 64'(cyc + 1 <= TMO + 4), 64'(1));

    // Outstanding limit, and wr_done coinciding with a grant.
    arm(64'h4_0000_0000, 1'b1);
    repeat (MAXO) req_chunk("E", 256);
    push_req(256);
    wait_gnt("E:blk5", 8, 1'b0);
    pulse_done(1);
    wait_gnt("E:gnt5", 10, 1'b1);
    pulse_done(1);
    bus.wr_done = 1'b1;
    push_req(256);
    wait_gnt("E:same_cyc", 10, 1'b1);
    req_chunk("E:gnt7", 256);
    push_req(256);
    wait_gnt("E:blk8", 8, 1'b0);

    // Reset while flushing with writes outstanding, then a clean re-arm.
    bus.chnk_req = 1'b0;
    void'(exp_q.pop_front());
    bus.chnk_len = 13'd4096;
    bus.chnk_req = 1'b1;
    repeat (3) @(negedge clk);
    pulse_done(1);
    bus.chnk_req  = 1'b0;
    rst           = 1'b1;
    bus.lbuf_addr = 64'h3_0000_0000;
    bus.lbuf64b   = 1'b1;
    @(negedge clk);
    check_reset("F:rst");
    @(negedge clk);
    rst    = 1'b0;
    m_base = 64'h3_0000_0000;
    m_64   = 1'b1;
    m_off  = START;
    watch_idle("F:empty", 2 * TMO);
    repeat (MAXO) req_chunk("F", 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
